// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
// display_scan : multiplexed 7-segment scanner with PWM, blanking, double buffer
// Revision 1.0 - initial release
// ============================================================================
module display_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int STEP_DIV   = 3125,
    parameter bit HEX_EN     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic [6:0]              Sseg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anodos,
    output logic                    frame_done
);

    localparam int                    c_sc_w    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int                    c_idx_w   = $clog2(NUM_DIGITS);
    localparam logic [c_sc_w-1:0]     c_sc_max  = c_sc_w'(STEP_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_max = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_an_one  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [c_sc_w-1:0]       step_cnt_q, step_cnt_d;
    logic [3:0]              pwm_q, pwm_d;
    logic [c_idx_w-1:0]      idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic                    pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    bound_q, bound_d;
    logic [6:0]              sseg_q, sseg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   anodos_q, anodos_d;
    logic                    frame_done_q, frame_done_d;

    logic                    step_tick, slot_end, frame_bound, lit, zero_run;
    logic [NUM_DIGITS-1:0]   blanked_vec;
    logic [3:0]              cur_code;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = HEX_EN ? 7'b0001000 : 7'b1111111;
            4'hB: s = HEX_EN ? 7'b1100000 : 7'b1111111;
            4'hC: s = HEX_EN ? 7'b0110001 : 7'b1111111;
            4'hD: s = HEX_EN ? 7'b1000010 : 7'b1111111;
            4'hE: s = HEX_EN ? 7'b0110000 : 7'b1111111;
            default: s = HEX_EN ? 7'b0111000 : 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        step_tick   = (step_cnt_q == c_sc_max);
        slot_end    = step_tick && (pwm_q == 4'hF);
        frame_bound = slot_end && (idx_q == c_idx_max);

        step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
        pwm_d      = step_tick ? pwm_q + 4'd1 : pwm_q;
        idx_d      = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == c_idx_max) ? '0 : idx_q + 1'b1;
        end

        pend_digits_d = pend_digits_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;
        pend_lz_d     = pend_lz_q;
        pend_valid_d  = pend_valid_q;
        act_digits_d  = act_digits_q;
        act_dp_d      = act_dp_q;
        act_en_d      = act_en_q;
        act_lz_d      = act_lz_q;
        // Promotion uses the pending set as it was before this cycle, so a
        // load landing on the boundary cycle waits a full frame.
        if (frame_bound && pend_valid_q) begin
            act_digits_d = pend_digits_q;
            act_dp_d     = pend_dp_q;
            act_en_d     = pend_en_q;
            act_lz_d     = pend_lz_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_digits_d = digits;
            pend_dp_d     = dp;
            pend_en_d     = digit_en;
            pend_lz_d     = blank_lz;
            pend_valid_d  = 1'b1;
        end

        zero_run    = 1'b1;
        blanked_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run       = zero_run && (act_digits_q[4*i +: 4] == 4'd0);
            blanked_vec[i] = act_lz_q && (i != 0) && zero_run;
        end

        cur_code = act_digits_q[4*idx_q +: 4];
        lit      = act_en_q[idx_q] && (pwm_q < brightness) && !blanked_vec[idx_q];

        sseg_d   = 7'b1111111;
        dp_out_d = 1'b1;
        anodos_d = '1;
        if (lit) begin
            anodos_d = ~(c_an_one << idx_q);
            sseg_d   = seg_decode(cur_code);
            dp_out_d = ~act_dp_q[idx_q];
        end

        // Extra stage so frame_done lines up with the registered outputs.
        bound_d      = frame_bound;
        frame_done_d = bound_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q    <= '0;
            pwm_q         <= '0;
            idx_q         <= '0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_lz_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            act_lz_q      <= 1'b0;
            bound_q       <= 1'b0;
            sseg_q        <= 7'b1111111;
            dp_out_q      <= 1'b1;
            anodos_q      <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            step_cnt_q    <= step_cnt_d;
            pwm_q         <= pwm_d;
            idx_q         <= idx_d;
            pend_digits_q <= pend_digits_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            pend_lz_q     <= pend_lz_d;
            pend_valid_q  <= pend_valid_d;
            act_digits_q  <= act_digits_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            act_lz_q      <= act_lz_d;
            bound_q       <= bound_d;
            sseg_q        <= sseg_d;
            dp_out_q      <= dp_out_d;
            anodos_q      <= anodos_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign Sseg       = sseg_q;
    assign dp_out     = dp_out_q;
    assign anodos     = anodos_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
